datapath: RTL and testbench
===========================

# datapath

Register-transfer datapath of the accumulator processor, directly downstream of the control unit. It consumes the control unit's write/select/operation strobes and updates the architectural registers AC, PC, REM, RDM, RI, N, Z and OUT. It drives the external memory port and returns the decoded instruction and flag lines (sNOP…sHLT, sDIR…sSOP, sN, sZ) that the control unit reads.

## Interface
- WIDTH, 8, data and address width in bits; the instruction encoding below requires 8.
- clk  in  1  system clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- writeAC, writePC, writeN, writeZ, writeRDM, writeRI, writeOUT, writeREM, writeMEM  in  1 each  register/memory write strobes.
- selectREM  in  1  REM source: 0 = PC, 1 = RDM.
- incrementPC  in  1  PC <= PC+1.
- selectRDM  in  2  RDM source: 00 = mem_rdata, 01 = AC, 10 = in_data, 11 = hold.
- opULA  in  3  ALU operation.
- in_data  in  8  input-port value (IN).
- mem_rdata  in  8  combinational read data at mem_addr.
- mem_addr  out  8  equals REM.
- mem_wdata  out  8  equals RDM.
- mem_we  out  1  equals writeMEM.
- out_data  out  8  OUT register.
- sNOP, sSTA, sLDA, sADD, sSUB, sAND, sOR, sNOT, sJ, sJN, sJZ, sIN, sOUT, sSHR, sSHL, sHLT  out  1 each  one-hot opcode decode of RI[7:4] = 0x0…0xF, in that order.
- sDIR, sIND, sIM, sSOP  out  1 each  one-hot addressing-mode decode of RI[1:0] = 00, 01, 10, 11.
- sN, sZ  out  1  N and Z flag registers.

## Operation
- Every register samples pre-edge values. Simultaneous strobes never chain within a cycle: writeRDM with writeRI loads RI with the old RDM; writeRDM with writeMEM writes the old RDM to memory.
- REM: writeREM loads PC or RDM per selectREM.
- RDM: writeRDM loads per selectRDM; code 11 holds.
- RI: writeRI loads RDM.
- PC: writePC loads RDM. Otherwise incrementPC adds 1, wrapping modulo 256 (0xFF -> 0x00). When both are asserted, writePC wins.
- ALU result, 8 bits, modulo 256:
  - 000 = RDM (load)
  - 001 = AC+RDM
  - 010 = AC−RDM, two's complement
  - 011 = AC&RDM
  - 100 = AC|RDM
  - 101 = ~AC
  - 110 = AC>>1, logical
  - 111 = AC<<1, logical
- Carry and borrow are discarded.
- AC: writeAC loads the ALU result.
- N/Z: writeN loads result[7]; writeZ loads (result==0). Both strobes sample the same-cycle ALU result, independent of writeAC.
- OUT: writeOUT loads the pre-edge AC.
- Decode outputs are combinational from RI. The flag outputs are the flag registers.
- No internal state machine. Sequencing belongs to the control unit; this block is purely register-transfer.

## Timing
- Reset (rst_n low, asynchronous):
  - AC, PC, REM, RDM, RI, OUT = 0x00; N = Z = 0.
  - Hence sNOP = 1, sDIR = 1, all other decode outputs 0; mem_addr = 0x00, mem_wdata = 0x00, out_data = 0x00.
  - mem_we follows writeMEM combinationally. The control unit holds writeMEM low during reset.
- Reset asserted mid-instruction clears all registers immediately, without waiting for a clock edge. After release, the first rising edge applies strobes normally.
- Register latency is 1 cycle: a strobe at edge k makes the new value visible after edge k.
- Decode outputs and sN/sZ change in the same cycle RI or the flags change. The control unit samples them at the next edge.
- Memory read: REM loaded at edge k; mem_rdata captured into RDM at edge k+1 with writeRDM, selectRDM = 00.
- Memory write occurs at the edge where mem_we = 1, using REM and RDM as they were before that edge.
- Fetch sequence, 3 edges:
  - edge 1: writeREM, selectREM = 0
  - edge 2: writeRDM from memory, incrementPC
  - edge 3: writeRI

## Test plan
- Reset then fetch: memory[0x00] = 0x20, run the fetch sequence → RI = 0x20, sLDA = 1, sDIR = 1, PC = 0x01.
- ADD with wrap: AC = 0xF0, RDM = 0x20, opULA = 001, writeAC/N/Z → AC = 0x10, N = 0, Z = 0. Then AC = 0x80, RDM = 0x80, ADD → AC = 0x00, Z = 1, N = 0.
- SUB/NOT/shift: AC = 0x05, RDM = 0x06, SUB → AC = 0xFF, N = 1. Then NOT → AC = 0x00, Z = 1. Then AC = 0x81, SHR → 0x40; SHL on 0x81 → 0x02.
- Store/hazard: AC = 0x5A, REM = 0x33, RDM = 0x11; assert writeRDM (selectRDM = 01) with writeMEM → memory[0x33] = 0x11 and RDM = 0x5A after the edge.
- PC priority and wrap: PC = 0xFF, incrementPC → 0x00. RDM = 0x44, writePC with incrementPC → PC = 0x44.
- Async reset mid-operation: AC = 0x7E, OUT = 0x7E; pulse rst_n low between clock edges → all registers 0x00 immediately. IN then OUT: in_data = 0xC3, selectRDM = 10, then opULA = 000, writeAC, then writeOUT → out_data = 0xC3 after 3 edges.

Source files
------------

// File: rtl/datapath.sv
// Register-transfer datapath of the accumulator processor: AC, PC, REM, RDM, RI, N, Z, OUT,
// the ALU, the memory port and the combinational instruction/mode decode fed back to control.
module datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             writeAC,
    input  logic             writePC,
    input  logic             writeN,
    input  logic             writeZ,
    input  logic             writeRDM,
    input  logic             writeRI,
    input  logic             writeOUT,
    input  logic             writeREM,
    input  logic             writeMEM,
    input  logic             selectREM,
    input  logic             incrementPC,
    input  logic [1:0]       selectRDM,
    input  logic [2:0]       opULA,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] out_data,
    output logic             sNOP,
    output logic             sSTA,
    output logic             sLDA,
    output logic             sADD,
    output logic             sSUB,
    output logic             sAND,
    output logic             sOR,
    output logic             sNOT,
    output logic             sJ,
    output logic             sJN,
    output logic             sJZ,
    output logic             sIN,
    output logic             sOUT,
    output logic             sSHR,
    output logic             sSHL,
    output logic             sHLT,
    output logic             sDIR,
    output logic             sIND,
    output logic             sIM,
    output logic             sSOP,
    output logic             sN,
    output logic             sZ
);

    logic [WIDTH-1:0] ac_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] rdm_reg;
    logic [WIDTH-1:0] out_reg;
    // RI keeps only the opcode and mode fields; bits [3:2] are never decoded.
    logic [3:0]       ri_op_reg;
    logic [1:0]       ri_mode_reg;
    logic             n_reg;
    logic             z_reg;

    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] rdm_next;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] pc_next;
    logic [15:0]      op_dec;
    logic [3:0]       mode_dec;

    always_comb begin
        alu_result = rdm_reg;
        case (opULA)
            3'b000:  alu_result = rdm_reg;
            3'b001:  alu_result = ac_reg + rdm_reg;
            3'b010:  alu_result = ac_reg - rdm_reg;
            3'b011:  alu_result = ac_reg & rdm_reg;
            3'b100:  alu_result = ac_reg | rdm_reg;
            3'b101:  alu_result = ~ac_reg;
            3'b110:  alu_result = ac_reg >> 1;
            3'b111:  alu_result = ac_reg << 1;
            default: alu_result = rdm_reg;
        endcase
    end

    always_comb begin
        rdm_next = rdm_reg;
        case (selectRDM)
            2'b00:   rdm_next = mem_rdata;
            2'b01:   rdm_next = ac_reg;
            2'b10:   rdm_next = in_data;
            default: rdm_next = rdm_reg;
        endcase
    end

    assign rem_next = selectREM ? rdm_reg : pc_reg;

    always_comb begin
        pc_next = pc_reg;
        if (writePC) begin
            pc_next = rdm_reg;
        end else if (incrementPC) begin
            pc_next = pc_reg + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // All registers sample pre-edge values, so simultaneous strobes never chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_reg      <= '0;
            pc_reg      <= '0;
            rem_reg     <= '0;
            rdm_reg     <= '0;
            out_reg     <= '0;
            ri_op_reg   <= '0;
            ri_mode_reg <= '0;
            n_reg       <= 1'b0;
            z_reg       <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            if (writeAC)  ac_reg  <= alu_result;
            if (writeREM) rem_reg <= rem_next;
            if (writeRDM) rdm_reg <= rdm_next;
            if (writeOUT) out_reg <= ac_reg;
            if (writeRI) begin
                ri_op_reg   <= rdm_reg[7:4];
                ri_mode_reg <= rdm_reg[1:0];
            end
            if (writeN) n_reg <= alu_result[WIDTH-1];
            if (writeZ) z_reg <= (alu_result == '0);
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_op_dec
            assign op_dec[gi] = (ri_op_reg == 4'(gi));
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_mode_dec
            assign mode_dec[gi] = (ri_mode_reg == 2'(gi));
        end
    endgenerate

    assign sNOP = op_dec[0];
    assign sSTA = op_dec[1];
    assign sLDA = op_dec[2];
    assign sADD = op_dec[3];
    assign sSUB = op_dec[4];
    assign sAND = op_dec[5];
    assign sOR  = op_dec[6];
    assign sNOT = op_dec[7];
    assign sJ   = op_dec[8];
    assign sJN  = op_dec[9];
    assign sJZ  = op_dec[10];
    assign sIN  = op_dec[11];
    assign sOUT = op_dec[12];
    assign sSHR = op_dec[13];
    assign sSHL = op_dec[14];
    assign sHLT = op_dec[15];

    assign sDIR = mode_dec[0];
    assign sIND = mode_dec[1];
    assign sIM  = mode_dec[2];
    assign sSOP = mode_dec[3];

    assign sN        = n_reg;
    assign sZ        = z_reg;
    assign mem_addr  = rem_reg;
    assign mem_wdata = rdm_reg;
    assign mem_we    = writeMEM;
    assign out_data  = out_reg;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: table-driven ALU and decode vectors plus hand sequences
// for fetch, store hazard, PC priority/wrap and asynchronous reset.
module tb_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       writeAC, writePC, writeN, writeZ, writeRDM, writeRI, writeOUT, writeREM, writeMEM;
    logic       selectREM, incrementPC;
    logic [1:0] selectRDM;
    logic [2:0] opULA;
    logic [7:0] in_data, mem_rdata, mem_addr, mem_wdata, out_data;
    logic       mem_we;
    logic       sNOP, sSTA, sLDA, sADD, sSUB, sAND, sOR, sNOT, sJ, sJN, sJZ, sIN, sOUT, sSHR, sSHL, sHLT;
    logic       sDIR, sIND, sIM, sSOP, sN, sZ;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .writeAC(writeAC), .writePC(writePC), .writeN(writeN), .writeZ(writeZ),
        .writeRDM(writeRDM), .writeRI(writeRI), .writeOUT(writeOUT), .writeREM(writeREM),
        .writeMEM(writeMEM), .selectREM(selectREM), .incrementPC(incrementPC),
        .selectRDM(selectRDM), .opULA(opULA), .in_data(in_data), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .out_data(out_data),
        .sNOP(sNOP), .sSTA(sSTA), .sLDA(sLDA), .sADD(sADD), .sSUB(sSUB), .sAND(sAND),
        .sOR(sOR), .sNOT(sNOT), .sJ(sJ), .sJN(sJN), .sJZ(sJZ), .sIN(sIN), .sOUT(sOUT),
        .sSHR(sSHR), .sSHL(sSHL), .sHLT(sHLT), .sDIR(sDIR), .sIND(sIND), .sIM(sIM),
        .sSOP(sSOP), .sN(sN), .sZ(sZ)
    );

    // External memory: combinational read, write on the edge with pre-edge address/data.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    wire [15:0] op_bus   = {sHLT, sSHL, sSHR, sOUT, sIN, sJZ, sJN, sJ,
                            sNOT, sOR, sAND, sSUB, sADD, sLDA, sSTA, sNOP};
    wire [3:0]  mode_bus = {sSOP, sIM, sIND, sDIR};

    typedef struct {
        logic [7:0] ac;
        logic [7:0] rdm;
        logic [2:0] op;
        logic [7:0] res;
        logic       n;
        logic       z;
    } alu_vec_t;

    alu_vec_t alu_tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic idle();
        writeAC = 0; writePC = 0; writeN = 0; writeZ = 0; writeRDM = 0; writeRI = 0;
        writeOUT = 0; writeREM = 0; writeMEM = 0; selectREM = 0; incrementPC = 0;
        selectRDM = 2'b11; opULA = 3'b000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_rdm(input logic [7:0] v);
        in_data = v; selectRDM = 2'b10; writeRDM = 1; step();
    endtask

    task automatic load_ac(input logic [7:0] v);
        load_rdm(v);
        opULA = 3'b000; writeAC = 1; step();
    endtask

    task automatic read_ac(output logic [7:0] v);
        writeOUT = 1; step();
        v = out_data;
    endtask

    task automatic read_pc(output logic [7:0] v);
        selectREM = 0; writeREM = 1; step();
        v = mem_addr;
    endtask

    logic [7:0] val;

    initial begin
        alu_tbl[0]  = '{ac: 8'hF0, rdm: 8'h20, op: 3'b001, res: 8'h10, n: 1'b0, z: 1'b0};
        alu_tbl[1]  = '{ac: 8'h80, rdm: 8'h80, op: 3'b001, res: 8'h00, n: 1'b0, z: 1'b1};
        alu_tbl[2]  = '{ac: 8'h05, rdm: 8'h06, op: 3'b010, res: 8'hFF, n: 1'b1, z: 1'b0};
        alu_tbl[3]  = '{ac: 8'h30, rdm: 8'h10, op: 3'b010, res: 8'h20, n: 1'b0, z: 1'b0};
        alu_tbl[4]  = '{ac: 8'hF0, rdm: 8'h3C, op: 3'b011, res: 8'h30, n: 1'b0, z: 1'b0};
        alu_tbl[5]  = '{ac: 8'h0F, rdm: 8'hB0, op: 3'b100, res: 8'hBF, n: 1'b1, z: 1'b0};
        alu_tbl[6]  = '{ac: 8'hFF, rdm: 8'h12, op: 3'b101, res: 8'h00, n: 1'b0, z: 1'b1};
        alu_tbl[7]  = '{ac: 8'h81, rdm: 8'h00, op: 3'b110, res: 8'h40, n: 1'b0, z: 1'b0};
        alu_tbl[8]  = '{ac: 8'h81, rdm: 8'h00, op: 3'b111, res: 8'h02, n: 1'b0, z: 1'b0};
        alu_tbl[9]  = '{ac: 8'h40, rdm: 8'h00, op: 3'b111, res: 8'h80, n: 1'b1, z: 1'b0};
        alu_tbl[10] = '{ac: 8'h55, rdm: 8'h00, op: 3'b000, res: 8'h00, n: 1'b0, z: 1'b1};
        alu_tbl[11] = '{ac: 8'h00, rdm: 8'h9C, op: 3'b000, res: 8'h9C, n: 1'b1, z: 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h20;
        idle();
        in_data = 8'h00;
        rst_n = 0;
        #12;
        check("reset mem_addr", 32'(mem_addr), 32'h00);
        check("reset mem_wdata", 32'(mem_wdata), 32'h00);
        check("reset out_data", 32'(out_data), 32'h00);
        check("reset flags", 32'({sN, sZ}), 32'h0);
        check("reset op decode", 32'(op_bus), 32'h0001);
        check("reset mode decode", 32'(mode_bus), 32'h1);
        check("reset mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        rst_n = 1;
        step();

        // Fetch: REM<=PC, RDM<=mem & PC++, RI<=RDM
        selectREM = 0; writeREM = 1; step();
        selectRDM = 2'b00; writeRDM = 1; incrementPC = 1; step();
        check("fetch rdm", 32'(mem_wdata), 32'h20);
        writeRI = 1; step();
        check("fetch sLDA", 32'(sLDA), 32'h1);
        check("fetch sDIR", 32'(sDIR), 32'h1);
        check("fetch op decode", 32'(op_bus), 32'h0004);
        read_pc(val);
        check("fetch pc", 32'(val), 32'h01);

        for (int i = 0; i < 12; i++) begin
            load_ac(alu_tbl[i].ac);
            load_rdm(alu_tbl[i].rdm);
            opULA = alu_tbl[i].op; writeAC = 1; writeN = 1; writeZ = 1; step();
            check($sformatf("alu[%0d] N", i), 32'(sN), 32'(alu_tbl[i].n));
            check($sformatf("alu[%0d] Z", i), 32'(sZ), 32'(alu_tbl[i].z));
            read_ac(val);
            check($sformatf("alu[%0d] AC op%0d", i, alu_tbl[i].op), 32'(val), 32'(alu_tbl[i].res));
        end

        // Flags update from the ALU even without writeAC
        load_ac(8'h01);
        load_rdm(8'h01);
        opULA = 3'b010; writeN = 1; writeZ = 1; step();
        check("flags w/o writeAC Z", 32'(sZ), 32'h1);
        read_ac(val);
        check("AC unchanged w/o writeAC", 32'(val), 32'h01);

        for (int i = 0; i < 16; i++) begin
            logic [15:0] exp_op;
            logic [3:0]  exp_mode;
            exp_op   = 16'h0001 << i;
            exp_mode = 4'h1 << (i % 4);
            load_rdm({4'(i), 2'(i + 1), 2'(i % 4)});
            writeRI = 1; step();
            check($sformatf("decode op %0h", i), 32'(op_bus), 32'(exp_op));
            check($sformatf("decode mode %0d", i % 4), 32'(mode_bus), 32'(exp_mode));
        end

        // RI with simultaneous RDM load gets the old RDM
        load_rdm(8'h51);
        in_data = 8'h90; selectRDM = 2'b10; writeRDM = 1; writeRI = 1; step();
        check("RI takes old RDM", 32'({op_bus, mode_bus}), 32'({16'h0020, 4'h2}));
        check("RDM took new value", 32'(mem_wdata), 32'h90);

        // Store with simultaneous RDM<=AC writes the old RDM
        load_ac(8'h5A);
        load_rdm(8'h33);
        selectREM = 1; writeREM = 1; step();
        load_rdm(8'h11);
        selectRDM = 2'b01; writeRDM = 1; writeMEM = 1;
        #1;
        check("mem_we follows writeMEM", 32'(mem_we), 32'h1);
        step();
        check("store mem[33]", 32'(mem[8'h33]), 32'h11);
        check("store RDM<=AC", 32'(mem_wdata), 32'h5A);
        check("store mem_addr", 32'(mem_addr), 32'h33);

        // Memory read: REM set, then RDM captures mem_rdata
        mem[8'h7A] = 8'hC6;
        load_rdm(8'h7A);
        selectREM = 1; writeREM = 1; step();
        selectRDM = 2'b00; writeRDM = 1; step();
        check("mem read into RDM", 32'(mem_wdata), 32'hC6);

        // PC wrap and writePC priority
        load_rdm(8'hFF);
        writePC = 1; step();
        incrementPC = 1; step();
        read_pc(val);
        check("pc wrap", 32'(val), 32'h00);
        load_rdm(8'h44);
        writePC = 1; incrementPC = 1; step();
        read_pc(val);
        check("pc writePC wins", 32'(val), 32'h44);
        incrementPC = 1; step();
        read_pc(val);
        check("pc increment", 32'(val), 32'h45);

        // Async reset between edges
        load_ac(8'h7E);
        writeOUT = 1; step();
        check("out before reset", 32'(out_data), 32'h7E);
        #2 rst_n = 0;
        #1;
        check("async reset out_data", 32'(out_data), 32'h00);
        check("async reset mem_wdata", 32'(mem_wdata), 32'h00);
        check("async reset mem_addr", 32'(mem_addr), 32'h00);
        check("async reset decode", 32'({op_bus, mode_bus}), 32'({16'h0001, 4'h1}));
        #1 rst_n = 1;
        read_ac(val);
        check("async reset AC", 32'(val), 32'h00);
        read_pc(val);
        check("async reset PC", 32'(val), 32'h00);

        // IN then OUT
        in_data = 8'hC3; selectRDM = 2'b10; writeRDM = 1; step();
        opULA = 3'b000; writeAC = 1; step();
        writeOUT = 1; step();
        check("IN to OUT", 32'(out_data), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
